// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes
// and the select/function codes driven onto the datapath.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRPC,
        S_LUI
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CMP   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the controller's coarse ALU request plus funct fields to an ALUControl code.
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        unique case (aluop)
            ALUOP_CMP: begin
                // beq/bne compare by subtraction, blt/bge by slt
                case (funct3)
                    3'b000, 3'b001: ALUControl = ALU_SUB;
                    3'b100, 3'b101: ALUControl = ALU_SLT;
                    default:        ALUControl = ALU_ADD;
                endcase
            end
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I datapath: sequences each
// instruction and drives every datapath select and write enable.
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] controllerSignal,
    input  logic        Zero,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResaultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        Illegal
);

    state_t     state, state_next;
    logic [1:0] aluop;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode      = controllerSignal[6:0];
    assign funct3      = controllerSignal[14:12];
    assign unused_bits = ^{controllerSignal[31], controllerSignal[29:15], controllerSignal[11:7]};

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7b5   (controllerSignal[30]),
        .is_rtype   (opcode == OP_RTYPE),
        .ALUControl (ALUControl)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_RESET;
        else      state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResaultSrc = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        ImmSrc     = IMM_I;
        aluop      = ALUOP_ADD;
        Illegal    = 1'b0;
        unique case (state)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResaultSrc = RES_ALU;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LOAD:   state_next = S_MEMADR;
                    OP_STORE:  begin state_next = S_MEMADR; ImmSrc = IMM_S; end
                    OP_RTYPE:  state_next = S_EXECR;
                    OP_IALU:   state_next = S_EXECI;
                    OP_BRANCH: begin state_next = S_BRANCH; ImmSrc = IMM_B; end
                    OP_JAL:    begin state_next = S_JAL;    ImmSrc = IMM_J; end
                    OP_JALR:   state_next = S_JALR;
                    OP_LUI:    begin state_next = S_LUI;    ImmSrc = IMM_U; end
                    default:   Illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResaultSrc = RES_DATA;
                RegWrite   = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_A;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_A;
                aluop   = ALUOP_CMP;
                // beq/bge take on Zero, bne/blt on !Zero
                case (funct3)
                    3'b000, 3'b101: PCWrite = Zero;
                    3'b001, 3'b100: PCWrite = ~Zero;
                    default:        PCWrite = 1'b0;
                endcase
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                state_next = S_JALRPC;
            end
            S_JALRPC: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = SRCA_ZERO;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_U;
                state_next = S_ALUWB;
            end
            default: state_next = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed test-plan cases then
// random instructions, each cycle compared against a per-instruction timeline model.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] controllerSignal = '0;
    logic        Zero = 1'b0;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0]  ResaultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSrc, ALUControl;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    multicycle_controller dut (
        .clk              (clk),
        .rst              (rst),
        .controllerSignal (controllerSignal),
        .Zero             (Zero),
        .PCWrite          (PCWrite),
        .AdrSrc           (AdrSrc),
        .MemWrite         (MemWrite),
        .IRWrite          (IRWrite),
        .RegWrite         (RegWrite),
        .ResaultSrc       (ResaultSrc),
        .ALUSrcA          (ALUSrcA),
        .ALUSrcB          (ALUSrcB),
        .ImmSrc           (ImmSrc),
        .ALUControl       (ALUControl),
        .Illegal          (Illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Output word layout: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,Res[1:0],SrcA[1:0],SrcB[1:0],Imm[2:0],ALU[2:0],Illegal}
    function automatic logic [31:0] pk(logic pcw, logic adr, logic mw, logic irw, logic rw,
                                       logic [1:0] res, logic [1:0] sa, logic [1:0] sb,
                                       logic [2:0] imm, logic [2:0] alu, logic ill);
        return {14'd0, pcw, adr, mw, irw, rw, res, sa, sb, imm, alu, ill};
    endfunction

    function automatic logic [31:0] observed();
        return {14'd0, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResaultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};
    endfunction

    function automatic bit known_op(logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
    endfunction

    function automatic int unsigned cpi(logic [31:0] ins);
        case (ins[6:0])
            7'h63:        return 3;
            7'h03, 7'h67: return 5;
            7'h33, 7'h13, 7'h23, 7'h6F, 7'h37: return 4;
            default:      return 2;
        endcase
    endfunction

    // Arithmetic op for R/I-ALU: 0 add,1 sub,2 and,3 or,4 slt,5 xor
    function automatic logic [2:0] arith(logic [2:0] f3, logic sub);
        case (f3)
            3'd0:    return sub ? 3'd1 : 3'd0;
            3'd2:    return 3'd4;
            3'd4:    return 3'd5;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] expect_at(logic [31:0] ins, int unsigned step, logic z);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [2:0] imm;
        logic       take;
        if (step == 0) return pk(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0);
        if (step == 1) begin
            imm = (op == 7'h23) ? 3'd1 : (op == 7'h63) ? 3'd2 : (op == 7'h6F) ? 3'd3 :
                  (op == 7'h37) ? 3'd4 : 3'd0;
            return pk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, imm, 3'd0, !known_op(op));
        end
        case (op)
            7'h03: case (step)
                2:       return pk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0);
                3:       return pk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
                default: return pk(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 0);
            endcase
            7'h23: if (step == 2) return pk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd1, 3'd0, 0);
                   else           return pk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
            7'h33: if (step == 2) return pk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, arith(f3, ins[30]), 0);
                   else           return pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
            7'h13: if (step == 2) return pk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, arith(f3, 1'b0), 0);
                   else           return pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
            7'h63: begin
                take = (f3 == 3'd0 || f3 == 3'd5) ? z : (f3 == 3'd1 || f3 == 3'd4) ? !z : 1'b0;
                return pk(take, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0,
                          (f3 <= 3'd1) ? 3'd1 : (f3 == 3'd4 || f3 == 3'd5) ? 3'd4 : 3'd0, 0);
            end
            7'h6F: if (step == 2) return pk(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0, 0);
                   else           return pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
            7'h67: case (step)
                2:       return pk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0);
                3:       return pk(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0, 0);
                default: return pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
            endcase
            7'h37: if (step == 2) return pk(0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd1, 3'd4, 3'd0, 0);
                   else           return pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
            default: return '0;
        endcase
    endfunction

    // Called at a falling edge while in FETCH; zmode 0/1 forces Zero, 2 randomizes it
    task automatic run_instr(input logic [31:0] ins, input int unsigned zmode, input string tag);
        controllerSignal = ins;
        for (int unsigned s = 0; s < cpi(ins); s++) begin
            Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            check($sformatf("%s ins=%h step%0d z=%0b", tag, ins, s, Zero), observed(), expect_at(ins, s, Zero));
            @(negedge clk);
        end
    endtask

    logic [31:0] rins;
    logic [6:0]  rop;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_hold", observed(), '0);
        rst = 1'b1;
        #1 check("reset_state_after_release", observed(), '0);
        @(negedge clk);

        run_instr(32'h00A00093, 2, "addi");
        run_instr(32'h00000063, 1, "beq_taken");
        run_instr(32'h00000063, 0, "beq_not");
        run_instr(32'h00004063, 0, "blt_taken");
        run_instr(32'h00004063, 1, "blt_not");
        run_instr(32'h00001063, 0, "bne_taken");
        run_instr(32'h00005063, 1, "bge_taken");
        run_instr(32'h0040A183, 2, "lw");
        run_instr(32'h0030A223, 2, "sw");
        run_instr(32'h000080E7, 2, "jalr");
        run_instr(32'h0000007F, 2, "illegal");
        run_instr(32'h0000006F, 2, "jal");
        run_instr(32'h000000B7, 2, "lui");
        run_instr(32'h40000033, 2, "sub");
        run_instr(32'h40000013, 2, "addi_f7");
        run_instr(32'h0000B033, 2, "r_f3_unsup");

        // Reset asserted while lw sits in MEMREAD
        controllerSignal = 32'h0040A183;
        for (int unsigned s = 0; s < 4; s++) begin
            #1 check($sformatf("lw_pre_reset step%0d", s), observed(), expect_at(32'h0040A183, s, 1'b0));
            if (s < 3) @(negedge clk);
        end
        rst = 1'b0;
        #1 check("async_reset_midlw", observed(), '0);
        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 check($sformatf("reset_held_c%0d", c), observed(), '0);
        end
        rst = 1'b1;
        #1 check("reset_state_after_midlw", observed(), '0);
        @(negedge clk);

        for (int unsigned n = 0; n < 200; n++) begin
            rins = $urandom;
            case ($urandom_range(0, 8))
                0: rop = 7'h33;
                1: rop = 7'h13;
                2: rop = 7'h03;
                3: rop = 7'h23;
                4: rop = 7'h63;
                5: rop = 7'h6F;
                6: rop = 7'h67;
                7: rop = 7'h37;
                default: begin
                    rop = 7'($urandom);
                    while (known_op(rop)) rop = 7'($urandom);
                end
            endcase
            rins[6:0] = rop;
            run_instr(rins, 2, "rand");
        end
        #1 check("final_fetch", observed(), expect_at(32'h0, 0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multi-cycle RV32I core: a Moore FSM that reads the latched instruction word and the ALU zero flag from the datapath and drives every datapath select and write enable, sequencing each instruction through fetch, decode, execute, memory and writeback cycles. It is the counterpart of the datapath. Its outputs connect one-to-one to the datapath control inputs, and its inputs come from the datapath's instruction and Zero outputs.

## Interface
- No parameters; all encodings are constants in the shared package.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- controllerSignal  in  32  latched instruction register contents
- Zero  in  1  ALU result == 0 (combinational, current cycle)
- PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath enables/selects
- ResaultSrc  out  2  00 ALUOut, 01 memory data reg, 10 ALU result
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A reg, 11 zero
- ALUSrcB  out  2  00 B reg, 01 ImmExt, 10 constant 4
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
- Illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
- Supported instructions:
  - R-type: add, sub, and, or, slt, xor
  - I-ALU: addi, andi, ori, slti, xori
  - lw, sw
  - beq, bne, blt, bge
  - jal, jalr, lui
- Outputs are a pure function of the state, except PCWrite in BRANCH (depends on Zero) and ALUControl in EXECR/EXECI (funct decode). Unlisted outputs are 0.
- States and outputs:
  - RESET: all outputs 0 -> FETCH.
  - FETCH: AdrSrc=0, IRWrite=1, SrcA=PC, SrcB=4, add, ResaultSrc=10, PCWrite=1 -> DECODE.
  - DECODE: SrcA=OldPC, SrcB=Imm, add, ImmSrc per opcode (ALUOut <= branch/jal target). Next state by opcode: lw/sw->MEMADR, R->EXECR, I-ALU->EXECI, branch->BRANCH, jal->JAL, jalr->JALR, lui->LUI, other->FETCH with Illegal=1.
  - MEMADR: SrcA=A, SrcB=Imm, add, ImmSrc I (lw) or S (sw) -> MEMREAD (lw) / MEMWRITE (sw).
  - MEMREAD: AdrSrc=1, ResaultSrc=00 -> MEMWB.
  - MEMWB: ResaultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResaultSrc=00, MemWrite=1 -> FETCH.
  - EXECR: SrcA=A, SrcB=B, ALUControl from funct3/funct7[5] -> ALUWB.
  - EXECI: SrcA=A, SrcB=Imm, ImmSrc I; funct7 ignored, so 0x0 is always addi -> ALUWB.
  - ALUWB: ResaultSrc=00, RegWrite=1 -> FETCH.
  - BRANCH: SrcA=A, SrcB=B, ResaultSrc=00. beq/bne use sub; blt/bge use slt. PCWrite = Zero (beq, bge) or !Zero (bne, blt) -> FETCH.
  - JAL: SrcA=OldPC, SrcB=4, add, ResaultSrc=00, PCWrite=1 -> ALUWB.
  - JALR: SrcA=A, SrcB=Imm, add, ImmSrc I -> JALRPC.
  - JALRPC: ResaultSrc=00, PCWrite=1, SrcA=OldPC, SrcB=4, add -> ALUWB.
  - LUI: SrcA=zero, SrcB=Imm, ImmSrc U, add -> ALUWB.
- Unsupported funct3 inside a supported opcode: treated as add. Illegal is not asserted.

## Timing
- State register updates on the rising edge of clk. rst low forces RESET immediately, mid-instruction included, and all outputs go to 0 combinationally.
- The first FETCH is the second rising edge after rst is released.
- CPI by class:
  - branch: 3
  - R, I-ALU, sw, jal, lui: 4
  - lw, jalr: 5
- PCWrite, RegWrite and MemWrite are never asserted in the same cycle as each other, except PCWrite with IRWrite in FETCH.
- Illegal opcode costs 2 cycles with no architectural write.

## Structure
- Package multicycle_pkg holds:
  - state enum
  - opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111)
  - ALUControl, ImmSrc, ALUSrcA/B and ResaultSrc codes
- Sub-module alu_decoder: inputs aluop[1:0] (add/sub-cmp/funct), funct3, funct7b5, is_rtype; output ALUControl. Combinational.
- Top module: state register, next-state logic, output decode.

## Test plan
- Reset then hold rst low 3 cycles mid-lw (asserted in MEMREAD) -> all outputs 0; after release, RESET then FETCH; no RegWrite pulse.
- controllerSignal=0x00A00093 (addi x1,x0,10) -> FETCH, DECODE, EXECI, ALUWB. In ALUWB: RegWrite=1, ResaultSrc=00. ALUControl=000 in EXECI.
- beq with Zero=1, then Zero=0 -> PCWrite=1 / 0 in BRANCH, ALUControl=001. Same for blt: Zero=0 gives PCWrite=1, ALUControl=100.
- lw 0x0040A183 -> 5 cycles. MEMREAD: AdrSrc=1. MEMWB: ResaultSrc=01, RegWrite=1. sw 0x0030A223 -> MemWrite=1 in cycle 4, ImmSrc=001.
- jalr 0x000080E7 -> JALR, JALRPC (PCWrite=1, ResaultSrc=00), ALUWB (RegWrite=1). Total 5 cycles.
- Opcode 0x7F -> Illegal=1 for one cycle in DECODE, next state FETCH, no writes.
